// File: rtl/dcache_line_fill_ctrl_if.sv
// rtl/dcache_line_fill_ctrl_if.sv - cache-side fill handshake and word-wide memory port
interface dcache_line_fill_ctrl_if #(
    parameter int WORDS = 4
);
    logic                  fill_req;
    logic                  fill_ready;
    logic [31:0]           fill_addr;
    logic                  victim_dirty;
    logic [31:0]           victim_addr;
    logic [WORDS*32-1:0]   victim_data;
    logic                  busy;
    logic                  fill_done;
    logic [WORDS*32-1:0]   line_data;
    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output fill_req, fill_addr, victim_dirty, victim_addr, victim_data, mem_ack, mem_rdata,
        input  fill_ready, busy, fill_done, line_data, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  fill_req, fill_addr, victim_dirty, victim_addr, victim_data, mem_ack, mem_rdata,
        output fill_ready, busy, fill_done, line_data, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_line_fill_ctrl.sv
// rtl/dcache_line_fill_ctrl.sv - dirty-victim writeback then word-by-word line refill engine
module dcache_line_fill_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    dcache_line_fill_ctrl_if.slave   bus_if
);
    localparam int OFF_W = $clog2(WORDS) + 2;
    localparam int CNT_W = $clog2(WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         fill_base_q, fill_base_d;
    logic [31:0]         victim_base_q, victim_base_d;
    logic [WORDS*32-1:0] victim_data_q, victim_data_d;
    logic [WORDS*32-1:0] line_q, line_d;

    logic        in_xfer;
    logic        ack;
    logic        last_word;
    logic [31:0] word_off;

    assign in_xfer   = (state_q == ST_WB) || (state_q == ST_RD);
    assign ack       = in_xfer && bus_if.mem_ack;
    assign last_word = (cnt_q == CNT_W'(WORDS - 1));
    assign word_off  = {{(32-OFF_W){1'b0}}, cnt_q, 2'b00};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fill_base_d   = fill_base_q;
        victim_base_d = victim_base_q;
        victim_data_d = victim_data_q;
        line_d        = line_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.fill_req) begin
                    fill_base_d   = {bus_if.fill_addr[31:OFF_W], {OFF_W{1'b0}}};
                    victim_base_d = {bus_if.victim_addr[31:OFF_W], {OFF_W{1'b0}}};
                    victim_data_d = bus_if.victim_data;
                    cnt_d         = '0;
                    state_d       = bus_if.victim_dirty ? ST_WB : ST_RD;
                end
            end
            ST_WB: begin
                if (ack) begin
                    // counter wraps to zero on the last word, ready for the read phase
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (ack) begin
                    line_d[int'(cnt_q)*32 +: 32] = bus_if.mem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            fill_base_q   <= '0;
            victim_base_q <= '0;
            victim_data_q <= '0;
            line_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_base_q   <= fill_base_d;
            victim_base_q <= victim_base_d;
            victim_data_q <= victim_data_d;
            line_q        <= line_d;
        end
    end

    // Memory-port outputs are decoded from registered state so they hold steady across waits.
    always_comb begin
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        if (state_q == ST_WB) begin
            bus_if.mem_addr  = victim_base_q + word_off;
            bus_if.mem_wdata = victim_data_q[int'(cnt_q)*32 +: 32];
        end else if (state_q == ST_RD) begin
            bus_if.mem_addr  = fill_base_q + word_off;
        end
    end

    assign bus_if.mem_req    = in_xfer;
    assign bus_if.mem_we     = (state_q == ST_WB);
    assign bus_if.fill_ready = (state_q == ST_IDLE);
    assign bus_if.busy       = (state_q != ST_IDLE) || bus_if.fill_req;
    assign bus_if.fill_done  = (state_q == ST_DONE);
    assign bus_if.line_data  = line_q;
endmodule

// File: tb/tb_dcache_line_fill_ctrl.sv
// tb/tb_dcache_line_fill_ctrl.sv - directed self-checking bench for dcache_line_fill_ctrl
module tb_dcache_line_fill_ctrl;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst;

    dcache_line_fill_ctrl_if #(.WORDS(WORDS)) bus_if ();

    dcache_line_fill_ctrl #(.WORDS(WORDS)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] tx_addr  [0:31];
    logic        tx_we    [0:31];
    logic [31:0] tx_wdata [0:31];
    int          n_tx;
    int          done_cyc;
    int          gaps;
    int          unstable;

    function automatic logic [127:0] exp_line(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = (base + 32'(4*i)) ^ 32'hA5A5_A5A5;
        return l;
    endfunction

    // Drives one request from a negedge, acts as memory (ack every 'period' cycles), records traffic.
    task automatic run_fill(input logic dirty, input logic [31:0] faddr, input logic [31:0] vaddr,
                            input logic [127:0] vdata, input int period, input logic hold);
        int          wc;
        logic        mid;
        logic [31:0] p_addr;
        logic        p_we;
        logic [31:0] p_wdata;
        n_tx = 0; done_cyc = -1; gaps = 0; unstable = 0; wc = 0; mid = 1'b0;
        p_addr = '0; p_we = 1'b0; p_wdata = '0;
        bus_if.fill_req     = 1'b1;
        bus_if.fill_addr    = faddr;
        bus_if.victim_dirty = dirty;
        bus_if.victim_addr  = vaddr;
        bus_if.victim_data  = vdata;
        @(negedge clk);
        if (!hold) bus_if.fill_req = 1'b0;
        bus_if.fill_addr    = 32'hDEAD_BEEF;
        bus_if.victim_addr  = 32'hBEEF_0000;
        bus_if.victim_data  = '1;
        bus_if.victim_dirty = ~dirty;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bus_if.fill_done) begin
                done_cyc = cyc;
                break;
            end
            if (bus_if.mem_req) begin
                if (mid && (bus_if.mem_addr !== p_addr || bus_if.mem_we !== p_we ||
                            bus_if.mem_wdata !== p_wdata)) unstable++;
                p_addr = bus_if.mem_addr; p_we = bus_if.mem_we; p_wdata = bus_if.mem_wdata;
                mid = 1'b1;
                wc++;
                if (wc == period) begin
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = bus_if.mem_addr ^ 32'hA5A5_A5A5;
                    if (n_tx < 32) begin
                        tx_addr[n_tx] = bus_if.mem_addr;
                        tx_we[n_tx] = bus_if.mem_we;
                        tx_wdata[n_tx] = bus_if.mem_wdata;
                    end
                    n_tx++;
                    wc = 0;
                    mid = 1'b0;
                end else begin
                    bus_if.mem_ack = 1'b0;
                end
            end else begin
                gaps++;
                bus_if.mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.fill_req = 1'b0; bus_if.fill_addr = '0; bus_if.victim_dirty = 1'b0;
        bus_if.victim_addr = '0; bus_if.victim_data = '0; bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
        repeat (2) @(negedge clk);
        vectors++; if (bus_if.fill_ready !== 1'b1) begin miscompares++; $display("FAIL reset_fill_ready: got %b expected 1", bus_if.fill_ready); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        vectors++; if (bus_if.fill_done !== 1'b0) begin miscompares++; $display("FAIL reset_fill_done: got %b expected 0", bus_if.fill_done); end
        vectors++; if (bus_if.mem_req !== 1'b0 || bus_if.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_we: got %b%b expected 00", bus_if.mem_req, bus_if.mem_we); end
        vectors++; if (bus_if.mem_addr !== 32'h0 || bus_if.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr_wdata: got %h/%h expected 0/0", bus_if.mem_addr, bus_if.mem_wdata); end
        vectors++; if (bus_if.line_data !== 128'h0) begin miscompares++; $display("FAIL reset_line_data: got %h expected 0", bus_if.line_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_fill();
        vectors++; if (bus_if.fill_ready !== 1'b1) begin miscompares++; $display("FAIL clean_ready_before: got %b expected 1", bus_if.fill_ready); end
        bus_if.fill_req = 1'b1;
        #1;
        vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("FAIL clean_busy_on_accept: got %b expected 1", bus_if.busy); end
        run_fill(1'b0, 32'h0000_1234, 32'h0, 128'h0, 1, 1'b0);
        vectors++; if (n_tx !== 4) begin miscompares++; $display("FAIL clean_word_count: got %0d expected 4", n_tx); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_addr[i] !== 32'h1230 + 32'(4*i) || tx_we[i] !== 1'b0) begin
                miscompares++; $display("FAIL clean_read%0d: got %h we=%b expected %h we=0", i, tx_addr[i], tx_we[i], 32'h1230 + 32'(4*i));
            end
        end
        vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL clean_gaps: got %0d expected 0", gaps); end
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL clean_latency: got %0d expected 5", done_cyc); end
        vectors++; if (bus_if.line_data[31:0] !== 32'hA5A5_B795) begin miscompares++; $display("FAIL clean_word0: got %h expected a5a5b795", bus_if.line_data[31:0]); end
        vectors++; if (bus_if.line_data !== exp_line(32'h1230)) begin miscompares++; $display("FAIL clean_line: got %h expected %h", bus_if.line_data, exp_line(32'h1230)); end
        vectors++; if (bus_if.busy !== 1'b1 || bus_if.mem_req !== 1'b0) begin miscompares++; $display("FAIL clean_done_busy_req: got %b%b expected 10", bus_if.busy, bus_if.mem_req); end
        @(negedge clk);
        vectors++; if (bus_if.fill_done !== 1'b0 || bus_if.fill_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
            miscompares++; $display("FAIL clean_after_done: got done=%b ready=%b busy=%b expected 0 1 0", bus_if.fill_done, bus_if.fill_ready, bus_if.busy);
        end
        vectors++; if (bus_if.line_data !== exp_line(32'h1230)) begin miscompares++; $display("FAIL clean_line_hold: got %h expected %h", bus_if.line_data, exp_line(32'h1230)); end
    endtask

    task automatic test_dirty_fill();
        run_fill(1'b1, 32'h0000_3008, 32'h0000_2000, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 1'b0);
        vectors++; if (n_tx !== 8) begin miscompares++; $display("FAIL dirty_word_count: got %0d expected 8", n_tx); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_addr[i] !== 32'h2000 + 32'(4*i) || tx_we[i] !== 1'b1 || tx_wdata[i] !== 32'(17*(i+1))) begin
                miscompares++; $display("FAIL dirty_write%0d: got %h we=%b data=%h expected %h we=1 data=%h", i, tx_addr[i], tx_we[i], tx_wdata[i], 32'h2000 + 32'(4*i), 32'(17*(i+1)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_addr[i+4] !== 32'h3000 + 32'(4*i) || tx_we[i+4] !== 1'b0) begin
                miscompares++; $display("FAIL dirty_read%0d: got %h we=%b expected %h we=0", i, tx_addr[i+4], tx_we[i+4], 32'h3000 + 32'(4*i));
            end
        end
        vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL dirty_gaps: got %0d expected 0", gaps); end
        vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL dirty_latency: got %0d expected 9", done_cyc); end
        vectors++; if (bus_if.line_data !== exp_line(32'h3000)) begin miscompares++; $display("FAIL dirty_line: got %h expected %h", bus_if.line_data, exp_line(32'h3000)); end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic [127:0] held;
        run_fill(1'b0, 32'h0000_4004, 32'h0, 128'h0, 3, 1'b0);
        vectors++; if (done_cyc !== 13) begin miscompares++; $display("FAIL wait_latency: got %0d expected 13", done_cyc); end
        vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL wait_stability: got %0d changes expected 0", unstable); end
        vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL wait_gaps: got %0d expected 0", gaps); end
        vectors++; if (bus_if.line_data !== exp_line(32'h4000)) begin miscompares++; $display("FAIL wait_line: got %h expected %h", bus_if.line_data, exp_line(32'h4000)); end
        held = bus_if.line_data;
        @(negedge clk);
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h5A5A_5A5A;
        repeat (2) @(negedge clk);
        bus_if.mem_ack = 1'b0;
        vectors++; if (bus_if.fill_ready !== 1'b1 || bus_if.mem_req !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.fill_done !== 1'b0) begin
            miscompares++; $display("FAIL stray_ack_state: got ready=%b req=%b busy=%b done=%b expected 1 0 0 0", bus_if.fill_ready, bus_if.mem_req, bus_if.busy, bus_if.fill_done);
        end
        vectors++; if (bus_if.line_data !== held) begin miscompares++; $display("FAIL stray_ack_line: got %h expected %h", bus_if.line_data, held); end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        bus_if.fill_req = 1'b1; bus_if.fill_addr = 32'h0000_5000; bus_if.victim_dirty = 1'b0;
        @(negedge clk);
        bus_if.fill_req = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_if.mem_rdata = 32'h2222_2222;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus_if.fill_ready !== 1'b1 || bus_if.mem_req !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.fill_done !== 1'b0) begin
            miscompares++; $display("FAIL midreset_state: got ready=%b req=%b busy=%b done=%b expected 1 0 0 0", bus_if.fill_ready, bus_if.mem_req, bus_if.busy, bus_if.fill_done);
        end
        vectors++; if (bus_if.line_data !== 128'h0) begin miscompares++; $display("FAIL midreset_line: got %h expected 0", bus_if.line_data); end
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.fill_done) seen_done = 1'b1;
        end
        vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
        run_fill(1'b0, 32'h0000_6000, 32'h0, 128'h0, 1, 1'b0);
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL midreset_refill_latency: got %0d expected 5", done_cyc); end
        vectors++; if (bus_if.line_data !== exp_line(32'h6000)) begin miscompares++; $display("FAIL midreset_refill_line: got %h expected %h", bus_if.line_data, exp_line(32'h6000)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_fill(1'b0, 32'h0000_8000, 32'h0, 128'h0, 1, 1'b1);
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 5", done_cyc); end
        vectors++; if (bus_if.fill_ready !== 1'b0 || bus_if.busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_done_ready_busy: got ready=%b busy=%b expected 0 1", bus_if.fill_ready, bus_if.busy);
        end
        bus_if.fill_addr = 32'h0000_9990;
        @(negedge clk);
        vectors++; if (bus_if.fill_ready !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.fill_done !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle_accept: got ready=%b busy=%b done=%b expected 1 1 0", bus_if.fill_ready, bus_if.busy, bus_if.fill_done);
        end
        run_fill(1'b0, 32'h0000_7000, 32'h0, 128'h0, 1, 1'b0);
        vectors++; if (tx_addr[0] !== 32'h7000 || tx_addr[3] !== 32'h700C) begin
            miscompares++; $display("FAIL b2b_second_addr: got %h..%h expected 00007000..0000700c", tx_addr[0], tx_addr[3]);
        end
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 5", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_fill(1'b0, 32'hFFFF_FFF8, 32'h0, 128'h0, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_addr[i] !== 32'hFFFF_FFF0 + 32'(4*i)) begin
                miscompares++; $display("FAIL wrap_read%0d: got %h expected %h", i, tx_addr[i], 32'hFFFF_FFF0 + 32'(4*i));
            end
        end
        vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL wrap_latency: got %0d expected 5", done_cyc); end
        vectors++; if (bus_if.line_data !== exp_line(32'hFFFF_FFF0)) begin miscompares++; $display("FAIL wrap_line: got %h expected %h", bus_if.line_data, exp_line(32'hFFFF_FFF0)); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_fill();
        test_dirty_fill();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
